rng_seed_ctrl: RTL and testbench

Seed sequencer and word buffer wrapped around the 32-bit LFSR expansion stage. It drives the generator's 8-bit seed input and captures each registered 32-bit word one cycle after the seed settles. It then advances the seed with its own maximal-length 8-bit LFSR and queues words in a small FIFO. Consumers read from the FIFO through a valid/ready handshake. It sits between the CSR/seed-programming logic (upstream) and the random-word consumer (downstream).

---
 rtl/rng_seed_ctrl.sv | 123 ++++++++++++
 tb/tb_rng_seed_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/rng_seed_ctrl.sv
// rng_seed_ctrl: seed sequencer and word FIFO around the 32-bit LFSR expansion
// stage. Holds the seed steady for one SETTLE cycle, captures the generator's
// registered word in CAPTURE, then advances the seed with a maximal-length
// 8-bit LFSR (x^8+x^6+x^5+x^4+1).
//
// Handshake: word_out/word_valid are driven only from registered pointers and
// storage; a word is consumed on any rising edge where word_valid && word_ready
// are both high, unless seed_load is high in that cycle (the flush wins).
module rng_seed_ctrl #(
   parameter int          FIFO_DEPTH = 4,
   parameter logic [7:0]  SEED_RESET = 8'h01
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          seed_load,
   input  logic [7:0]                    seed_in,
   output logic [7:0]                    seed_val,
   input  logic [31:0]                   random_in,
   output logic [31:0]                   word_out,
   output logic                          word_valid,
   input  logic                          word_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fill_level,
   output logic                          seed_zero_err
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETTLE  = 2'd1,
      CAPTURE = 2'd2
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [7:0]      seed;
   logic [7:0]      seed_adv;
   logic [31:0]     mem [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic [CW-1:0]   count_next;
   logic            push;
   logic            pop;
   logic            zero_err;

   // A load flushes the FIFO, so it suppresses both the capture and the pop.
   assign push     = (state == CAPTURE) && !seed_load;
   assign pop      = word_valid && word_ready && !seed_load;
   assign seed_adv = {seed[6:0], seed[7] ^ seed[5] ^ seed[4] ^ seed[3]};

   assign seed_val      = seed;
   assign word_valid    = (count != '0);
   assign word_out      = word_valid ? mem[rd_ptr] : 32'd0;
   assign fill_level    = count;
   assign seed_zero_err = zero_err;

   // Occupancy after this cycle's push and pop; also steers the FSM.
   always_comb begin
      count_next = count;
      case ({push, pop})
         2'b10:   count_next = count + CW'(1);
         2'b01:   count_next = count - CW'(1);
         default: count_next = count;
      endcase
   end

   // Next-state logic: only start a SETTLE when there is room for its word.
   always_comb begin
      state_next = state;
      if (seed_load) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE:    state_next = (count_next < DEPTH_C) ? SETTLE : IDLE;
            SETTLE:  state_next = CAPTURE;
            CAPTURE: state_next = (count_next < DEPTH_C) ? SETTLE : IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Seed register: load (zero replaced) wins over the post-capture advance.
   always_ff @(posedge clk) begin
      if (rst) begin
         seed     <= SEED_RESET;
         zero_err <= 1'b0;
      end else begin
         zero_err <= seed_load && (seed_in == 8'd0);
         if (seed_load)
            seed <= (seed_in == 8'd0) ? SEED_RESET : seed_in;
         else if (push)
            seed <= seed_adv;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
   always_ff @(posedge clk) begin
      if (rst || seed_load) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count_next;
      end
   end

   // FIFO storage; contents are masked by word_valid so no reset is needed.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= random_in;
   end

endmodule

// File: tb/tb_rng_seed_ctrl.sv
// Directed bench for rng_seed_ctrl. A small registered generator model turns
// the seed into a recognisable 32-bit word; expected seed sequences are
// hand-derived from x^8+x^6+x^5+x^4+1 with feedback s7^s5^s4^s3.
module tb_rng_seed_ctrl;

   logic        clk;
   logic        rst;
   logic        seed_load;
   logic [7:0]  seed_in;
   logic [7:0]  seed_val;
   logic [31:0] random_in;
   logic [31:0] word_out;
   logic        word_valid;
   logic        word_ready;
   logic [2:0]  fill_level;
   logic        seed_zero_err;

   int checks = 0;
   int errors = 0;

   // Hand-derived LFSR order starting from 01.
   logic [7:0] seq [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11,
                            8'h23, 8'h47, 8'h8E, 8'h1C, 8'h38};

   rng_seed_ctrl #(.FIFO_DEPTH(4), .SEED_RESET(8'h01)) dut (
      .clk           (clk),
      .rst           (rst),
      .seed_load     (seed_load),
      .seed_in       (seed_in),
      .seed_val      (seed_val),
      .random_in     (random_in),
      .word_out      (word_out),
      .word_valid    (word_valid),
      .word_ready    (word_ready),
      .fill_level    (fill_level),
      .seed_zero_err (seed_zero_err)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] gen(input logic [7:0] s);
      return {s, ~s, s ^ 8'hA5, s + 8'd7};
   endfunction

   // generator model: registered, reflects the previous cycle's seed
   always @(posedge clk) random_in <= gen(seed_val);

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1; seed_load = 1'b0; seed_in = 8'h00; word_ready = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; seed_load = 1'b0; seed_in = 8'h00; word_ready = 1'b0;
      repeat (3) tick();
      checks++; if (seed_val !== 8'h01) begin errors++; $display("FAIL reset_seed got %h exp 01", seed_val); end
      checks++; if (word_out !== 32'd0) begin errors++; $display("FAIL reset_word got %h exp 0", word_out); end
      checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", word_valid); end
      checks++; if (fill_level !== 3'd0) begin errors++; $display("FAIL reset_fill got %0d exp 0", fill_level); end
      checks++; if (seed_zero_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", seed_zero_err); end
   endtask

   // Consumer stalled: captures in cycles 2,4,6,8; full with seed 11 from cycle 9.
   task automatic test_fill();
      int ef;
      do_reset();
      for (int c = 0; c <= 10; c++) begin
         ef = (c < 3) ? 0 : ((c >= 9) ? 4 : (c - 1) / 2);
         checks++; if (fill_level !== 3'(ef)) begin errors++; $display("FAIL fill_level c%0d got %0d exp %0d", c, fill_level, ef); end
         checks++; if (seed_val !== seq[ef]) begin errors++; $display("FAIL fill_seed c%0d got %h exp %h", c, seed_val, seq[ef]); end
         checks++; if (word_out !== ((ef > 0) ? gen(8'h01) : 32'd0)) begin errors++; $display("FAIL fill_head c%0d got %h", c, word_out); end
         if (c < 10) tick();
      end
   endtask

   // From full: one pop, refill SETTLE/CAPTURE, full again with the seed advanced.
   task automatic pop_refill(input int k);
      checks++; if (word_out !== gen(seq[k])) begin errors++; $display("FAIL drain_head k%0d got %h exp %h", k, word_out, gen(seq[k])); end
      word_ready = 1'b1;
      tick();
      word_ready = 1'b0;
      checks++; if (fill_level !== 3'd3) begin errors++; $display("FAIL drain_pop k%0d got %0d exp 3", k, fill_level); end
      tick();
      checks++; if (fill_level !== 3'd3) begin errors++; $display("FAIL drain_capt k%0d got %0d exp 3", k, fill_level); end
      tick();
      checks++; if (fill_level !== 3'd4) begin errors++; $display("FAIL drain_refill k%0d got %0d exp 4", k, fill_level); end
      checks++; if (seed_val !== seq[k+5]) begin errors++; $display("FAIL drain_seed k%0d got %h exp %h", k, seed_val, seq[k+5]); end
   endtask

   task automatic test_drain();
      // Fifth pop reads the seed-11 word, written at wrapped position 0.
      for (int k = 0; k < 5; k++) pop_refill(k);
   endtask

   // Consumer always ready: one word every 2 cycles, level never above 1.
   task automatic test_stream();
      int ef;
      do_reset();
      word_ready = 1'b1;
      for (int c = 0; c <= 14; c++) begin
         ef = (c >= 3 && (c % 2) == 1) ? 1 : 0;
         checks++; if (fill_level !== 3'(ef)) begin errors++; $display("FAIL stream_fill c%0d got %0d exp %0d", c, fill_level, ef); end
         checks++; if (word_out !== ((ef == 1) ? gen(seq[(c - 3) / 2]) : 32'd0)) begin errors++; $display("FAIL stream_word c%0d got %h", c, word_out); end
         tick();
      end
      word_ready = 1'b0;
   endtask

   // Pop during CAPTURE at level 2 keeps the level; order then checked on drain.
   task automatic test_back_to_back();
      logic [7:0] hs [7] = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h00, 8'h47};
      int         fs [7] = '{3, 2, 2, 1, 1, 0, 1};
      do_reset();
      repeat (6) tick();
      checks++; if (fill_level !== 3'd2) begin errors++; $display("FAIL b2b_pre got %0d exp 2", fill_level); end
      checks++; if (word_out !== gen(8'h01)) begin errors++; $display("FAIL b2b_head0 got %h", word_out); end
      word_ready = 1'b1;
      tick();
      word_ready = 1'b0;
      checks++; if (fill_level !== 3'd2) begin errors++; $display("FAIL b2b_level got %0d exp 2", fill_level); end
      checks++; if (word_out !== gen(8'h02)) begin errors++; $display("FAIL b2b_head1 got %h", word_out); end
      repeat (2) tick();
      word_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         checks++; if (fill_level !== 3'(fs[i])) begin errors++; $display("FAIL b2b_fill i%0d got %0d exp %0d", i, fill_level, fs[i]); end
         checks++; if (word_out !== ((fs[i] > 0) ? gen(hs[i]) : 32'd0)) begin errors++; $display("FAIL b2b_word i%0d got %h", i, word_out); end
         tick();
      end
      word_ready = 1'b0;
   endtask

   // Load during CAPTURE with 2 queued (and a pop attempt), then a zero load.
   task automatic test_seed_load();
      do_reset();
      repeat (6) tick();
      seed_load = 1'b1; seed_in = 8'hA5; word_ready = 1'b1;
      tick();
      seed_load = 1'b0; word_ready = 1'b0;
      checks++; if (fill_level !== 3'd0) begin errors++; $display("FAIL load_flush got %0d exp 0", fill_level); end
      checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL load_valid got %b exp 0", word_valid); end
      checks++; if (seed_val !== 8'hA5) begin errors++; $display("FAIL load_seed got %h exp a5", seed_val); end
      checks++; if (seed_zero_err !== 1'b0) begin errors++; $display("FAIL load_err got %b exp 0", seed_zero_err); end
      repeat (2) tick();
      checks++; if (fill_level !== 3'd0) begin errors++; $display("FAIL load_nopush got %0d exp 0", fill_level); end
      tick();
      checks++; if (fill_level !== 3'd1) begin errors++; $display("FAIL load_first got %0d exp 1", fill_level); end
      checks++; if (word_out !== gen(8'hA5)) begin errors++; $display("FAIL load_word got %h exp %h", word_out, gen(8'hA5)); end
      checks++; if (seed_val !== 8'h4A) begin errors++; $display("FAIL load_adv got %h exp 4a", seed_val); end
      seed_load = 1'b1; seed_in = 8'h00;
      tick();
      seed_load = 1'b0;
      checks++; if (seed_val !== 8'h01) begin errors++; $display("FAIL zero_seed got %h exp 01", seed_val); end
      checks++; if (seed_zero_err !== 1'b1) begin errors++; $display("FAIL zero_err_set got %b exp 1", seed_zero_err); end
      checks++; if (fill_level !== 3'd0) begin errors++; $display("FAIL zero_flush got %0d exp 0", fill_level); end
      tick();
      checks++; if (seed_zero_err !== 1'b0) begin errors++; $display("FAIL zero_err_pulse got %b exp 0", seed_zero_err); end
      repeat (2) tick();
      checks++; if (word_out !== gen(8'h01)) begin errors++; $display("FAIL zero_word got %h exp %h", word_out, gen(8'h01)); end
   endtask

   // Reset wins over a simultaneous load.
   task automatic test_reset_override();
      rst = 1'b1; seed_load = 1'b1; seed_in = 8'h33;
      tick();
      rst = 1'b0; seed_load = 1'b0;
      checks++; if (seed_val !== 8'h01) begin errors++; $display("FAIL rstov_seed got %h exp 01", seed_val); end
      checks++; if (fill_level !== 3'd0) begin errors++; $display("FAIL rstov_fill got %0d exp 0", fill_level); end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_stream();
      test_back_to_back();
      test_seed_load();
      test_reset_override();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
